// File: rtl/ghost_collision.sv
// Collision and lives controller: per-frame bounding-box test of Yoshi against
// three ghosts, with life loss, an invulnerability/blink window and game over.
module ghost_collision #(
  parameter int MAX_Y      = 480,
  parameter int T_W        = 16,
  parameter int MARGIN     = 4,
  parameter int LIVES_INIT = 3,
  parameter int INV_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] y_x,
  input  logic [9:0] y_y,
  input  logic [9:0] g_t_x,
  input  logic [9:0] g_t_y,
  input  logic [9:0] g_b_x,
  input  logic [9:0] g_b_y,
  input  logic [9:0] g_r_x,
  input  logic [9:0] g_r_y,
  input  logic       restart,
  output logic       hit,
  output logic [2:0] hit_src,
  output logic [1:0] lives,
  output logic       invuln,
  output logic       yoshi_visible,
  output logic       game_over
);

  typedef enum logic [1:0] {PLAY, HIT, OVER} state_t;

  localparam logic [10:0] W       = 11'(T_W - MARGIN);
  localparam logic [9:0]  MAX_Y_V = 10'(MAX_Y);
  localparam logic [1:0]  LIVES_V = 2'(LIVES_INIT);
  localparam logic [7:0]  INV_V   = 8'(INV_FRAMES - 1);

  // Zero-extended to 11 bits so a box near the right/bottom edge cannot wrap.
  function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay,
                                   input logic [9:0] bx, input logic [9:0] by);
    logic [10:0] axe, aye, bxe, bye;
    axe = {1'b0, ax};
    aye = {1'b0, ay};
    bxe = {1'b0, bx};
    bye = {1'b0, by};
    return (axe + W > bxe) && (bxe + W > axe) &&
           (aye + W > bye) && (bye + W > aye);
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lives_q, lives_d;
  logic [2:0]  src_q, src_d;
  logic        hit_q, hit_d;
  logic        inv_q, inv_d;
  logic        vis_q, vis_d;
  logic        over_q, over_d;
  logic        tick_lvl_q;
  logic        tick_lvl;
  logic        tick;
  logic [2:0]  ov;

  assign tick_lvl = (x == 10'd0) && (y == MAX_Y_V);
  // Only the first cycle of the tick condition counts if x lingers at 0.
  assign tick     = tick_lvl && !tick_lvl_q;
  assign ov       = {overlap(y_x, y_y, g_r_x, g_r_y),
                     overlap(y_x, y_y, g_b_x, g_b_y),
                     overlap(y_x, y_y, g_t_x, g_t_y)};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    src_d   = src_q;
    hit_d   = 1'b0;
    if (restart) begin
      state_d = PLAY;
      cnt_d   = 8'd0;
      lives_d = LIVES_V;
      src_d   = 3'b000;
    end else if (tick) begin
      case (state_q)
        PLAY: begin
          if (ov != 3'b000) begin
            hit_d = 1'b1;
            src_d = ov;
            if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              cnt_d   = INV_V;
              state_d = HIT;
            end else begin
              lives_d = 2'd0;
              state_d = OVER;
            end
          end
        end
        HIT: begin
          if (cnt_q == 8'd0) state_d = PLAY;
          else               cnt_d   = cnt_q - 8'd1;
        end
        OVER:    state_d = OVER;
        default: state_d = PLAY;
      endcase
    end
    inv_d  = (state_d == HIT);
    // Counter bit 3 flips every 8 frames, giving a 16-frame blink period.
    vis_d  = !((state_d == HIT) && cnt_d[3]);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PLAY;
      cnt_q      <= 8'd0;
      lives_q    <= LIVES_V;
      src_q      <= 3'b000;
      hit_q      <= 1'b0;
      inv_q      <= 1'b0;
      vis_q      <= 1'b1;
      over_q     <= 1'b0;
      tick_lvl_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lives_q    <= lives_d;
      src_q      <= src_d;
      hit_q      <= hit_d;
      inv_q      <= inv_d;
      vis_q      <= vis_d;
      over_q     <= over_d;
      tick_lvl_q <= tick_lvl;
    end
  end

  assign hit           = hit_q;
  assign hit_src       = src_q;
  assign lives         = lives_q;
  assign invuln        = inv_q;
  assign yoshi_visible = vis_q;
  assign game_over     = over_q;

endmodule
